// File: rtl/scarv_rom_bus_bridge.sv
// Memory bus to single-port ROM bridge with range/alignment/write checks
// and a two-entry response buffer for back-pressure.
module scarv_rom_bus_bridge #(
    parameter int unsigned DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          mem_req,
    output logic          mem_gnt,
    input  logic          mem_wen,
    input  logic [3:0]    mem_strb,
    input  logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_addr,
    input  logic          mem_recv,
    output logic          mem_ack,
    output logic          mem_error,
    output logic [31:0]   mem_rdata,
    output logic          rom_cen,
    output logic [AW-1:0] rom_addr,
    input  logic [31:0]   rom_rdata
);

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic [1:0]  count_q, count_d;
    logic        inflight_q, inflight_d;
    logic        ierr_q, ierr_d;
    resp_t       buf0_q, buf0_d;
    resp_t       buf1_q, buf1_d;

    logic [32:0] off;
    logic        bad;
    logic        gnt;
    logic        ack;
    logic        show_buf;
    logic        pop;
    logic        pop_buf;
    logic        push;
    logic [1:0]  count_mid;
    resp_t       resp_new;
    resp_t       shown;
    logic        unused_ok;

    // Borrow bit of the offset flags addresses below BASE.
    assign off = {1'b0, mem_addr} - {1'b0, BASE};
    assign bad = mem_wen | (mem_addr[1:0] != 2'b00) | off[32]
               | (off[31:AW+2] != '0);

    assign gnt = g_resetn & mem_req
               & (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);

    assign rom_cen  = gnt & ~bad;
    assign rom_addr = off[AW+1:2];

    assign resp_new.err  = ierr_q;
    assign resp_new.data = ierr_q ? 32'h0 : rom_rdata;

    assign show_buf = (count_q != 2'd0);
    assign shown    = show_buf ? buf0_q : resp_new;
    assign ack      = g_resetn & (show_buf | inflight_q);

    assign pop       = ack & mem_recv;
    assign pop_buf   = pop & show_buf;
    assign push      = inflight_q & ~(pop & ~show_buf);
    assign count_mid = count_q - {1'b0, pop_buf};

    assign mem_gnt   = gnt;
    assign mem_ack   = ack;
    assign mem_error = ack & shown.err;
    assign mem_rdata = ack ? shown.data : 32'h0;

    assign unused_ok = ^{mem_strb, mem_wdata, off[1:0]};

    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        count_d    = count_mid + {1'b0, push};
        inflight_d = gnt;
        ierr_d     = gnt & bad;
        if (pop_buf) begin
            buf0_d = buf1_q;
            buf1_d = '0;
        end
        if (push) begin
            if (count_mid == 2'd0) buf0_d = resp_new;
            else                   buf1_d = resp_new;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            ierr_q     <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            ierr_q     <= ierr_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    count_ok: assert property (
        @(posedge g_clk) disable iff (!g_resetn) count_q <= 2'd2
    );

endmodule
